// File: rtl/msg512_unpack_if.sv
// Handshake bundle for msg512_unpack: padded-block input side and byte-stream output side.
interface msg512_unpack_if #(
  parameter int LEN_W = 6
);
  logic             block_valid;
  logic             block_ready;
  logic [511:0]     message_vector;
  logic             msg_valid;
  logic             msg_ready;
  logic [LEN_W-1:0] msg_address;
  logic [7:0]       msg_data;
  logic             unpack_done;
  logic             pad_error;
  logic [LEN_W-1:0] msg_length;

  modport master (
    output block_valid, message_vector, msg_ready,
    input  block_ready, msg_valid, msg_address, msg_data, unpack_done, pad_error, msg_length
  );

  modport slave (
    input  block_valid, message_vector, msg_ready,
    output block_ready, msg_valid, msg_address, msg_data, unpack_done, pad_error, msg_length
  );
endinterface

// File: rtl/msg512_unpack.sv
// Validates the padding of one 512-bit SHA-256 block and replays its message bytes as an
// (address, data) stream. Optional macro UNPACK_ZERO_CHECK_EN enforces an all-zero fill.
module msg512_unpack #(
  parameter int MSG_LENGTH = 55
) (
  input  logic           clock,
  input  logic           reset_n,
  msg512_unpack_if.slave bus
);
  localparam int LEN_W = $clog2(MSG_LENGTH);

  typedef enum logic [2:0] {IDLE, CHECK, EMIT, DONE, ERROR} state_t;

  state_t           state, nxt;
  logic [511:0]     blk, blk_n;
  logic [LEN_W-1:0] len, len_n, addr, addr_n;
  logic [7:0]       data, data_n;
  logic             valid, valid_n, ready, ready_n, done, done_n, perr, perr_n;
  logic [8:0]       marker;
  logic             bad;

  // Byte a sits MSB-first at bits [511-8a -: 8].
  function automatic logic [7:0] byte_at(input logic [511:0] b, input logic [LEN_W-1:0] a);
    logic [8:0] top;
    top = 9'(511 - 8 * int'(a));
    return b[top -: 8];
  endfunction

`ifdef UNPACK_ZERO_CHECK_EN
  function automatic logic fill_dirty(input logic [511:0] b, input logic [LEN_W-1:0] l);
    logic dirty;
    dirty = 1'b0;
    for (int i = LEN_W; i < 511; i++) begin
      if ((i <= 510 - 8 * int'(l)) && b[i]) begin
        dirty = 1'b1;
      end else begin
        dirty = dirty;
      end
    end
    return dirty;
  endfunction
`endif

  // Next-state and next-output logic
  always_comb begin
    nxt     = state;
    blk_n   = blk;
    len_n   = len;
    addr_n  = addr;
    data_n  = data;
    valid_n = valid;
    done_n  = 1'b0;
    perr_n  = perr;
    marker  = 9'(511 - 8 * int'(len));
`ifdef UNPACK_ZERO_CHECK_EN
    bad = (int'(len) > MSG_LENGTH) || (blk[marker] != 1'b1) || fill_dirty(blk, len);
`else
    bad = (int'(len) > MSG_LENGTH) || (blk[marker] != 1'b1);
`endif
    case (state)
      IDLE: begin
        if (bus.block_valid) begin
          blk_n  = bus.message_vector;
          len_n  = bus.message_vector[LEN_W-1:0];
          perr_n = 1'b0;
          nxt    = CHECK;
        end else begin
          nxt = IDLE;
        end
      end
      CHECK: begin
        if (bad) begin
          perr_n = 1'b1;
          done_n = 1'b1;
          nxt    = ERROR;
        end else if (len == '0) begin
          done_n = 1'b1;
          nxt    = DONE;
        end else begin
          addr_n  = '0;
          data_n  = byte_at(blk, '0);
          valid_n = 1'b1;
          nxt     = EMIT;
        end
      end
      EMIT: begin
        if (bus.msg_ready) begin
          if (addr == len - LEN_W'(1)) begin
            valid_n = 1'b0;
            done_n  = 1'b1;
            nxt     = DONE;
          end else begin
            addr_n = addr + LEN_W'(1);
            data_n = byte_at(blk, addr + LEN_W'(1));
            nxt    = EMIT;
          end
        end else begin
          nxt = EMIT;
        end
      end
      DONE:    nxt = IDLE;
      ERROR:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
    ready_n = (nxt == IDLE);
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      blk   <= '0;
      len   <= '0;
      addr  <= '0;
      data  <= 8'h00;
      valid <= 1'b0;
      ready <= 1'b1;
      done  <= 1'b0;
      perr  <= 1'b0;
    end else begin
      state <= nxt;
      blk   <= blk_n;
      len   <= len_n;
      addr  <= addr_n;
      data  <= data_n;
      valid <= valid_n;
      ready <= ready_n;
      done  <= done_n;
      perr  <= perr_n;
    end
  end

  assign bus.block_ready = ready;
  assign bus.msg_valid   = valid;
  assign bus.msg_address = addr;
  assign bus.msg_data    = data;
  assign bus.unpack_done = done;
  assign bus.pad_error   = perr;
  assign bus.msg_length  = len;
endmodule

// File: tb/tb_msg512_unpack.sv
// Scoreboard bench for msg512_unpack: directed blocks push expected bytes/done records,
// an independent negedge monitor pops and compares.
module tb_msg512_unpack;
  localparam int LEN_W = $clog2(55);

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  msg512_unpack_if #(.LEN_W(LEN_W)) bus ();

  msg512_unpack #(.MSG_LENGTH(55)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {int addr; int data;} byte_t;
  typedef struct {int perr; int len; int lat;} done_t;

  byte_t byte_q[$];
  done_t done_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit prev_stall = 1'b0;
  int prev_addr = 0;
  int prev_data = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: compares every handshake and done pulse against the scoreboard
  always @(negedge clock) begin
    byte_t b;
    done_t d;
    cyc++;
    if (reset_n) begin
      if (bus.block_valid && bus.block_ready) acc_cyc = cyc;
      if (prev_stall) begin
        check("stall_valid", int'(bus.msg_valid), 1);
        check("stall_addr", int'(bus.msg_address), prev_addr);
        check("stall_data", int'(bus.msg_data), prev_data);
      end
      if (bus.msg_valid && bus.msg_ready) begin
        if (byte_q.size() == 0) begin
          check("unexpected_byte", int'(bus.msg_address), -1);
        end else begin
          b = byte_q.pop_front();
          check("byte_addr", int'(bus.msg_address), b.addr);
          check("byte_data", int'(bus.msg_data), b.data);
        end
      end
      if (bus.unpack_done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          d = done_q.pop_front();
          check("pad_error", int'(bus.pad_error), d.perr);
          check("msg_length", int'(bus.msg_length), d.len);
          check("bytes_left", byte_q.size(), 0);
          check("done_latency", cyc - acc_cyc, d.lat);
        end
      end
    end
    prev_stall = reset_n && bus.msg_valid && !bus.msg_ready;
    prev_addr  = int'(bus.msg_address);
    prev_data  = int'(bus.msg_data);
  end

  task automatic exp_byte(input int a, input int v);
    byte_t b;
    b.addr = a;
    b.data = v;
    byte_q.push_back(b);
  endtask

  task automatic exp_done(input int perr, input int len, input int lat);
    done_t d;
    d.perr = perr;
    d.len  = len;
    d.lat  = lat;
    done_q.push_back(d);
  endtask

  task automatic exp_abc();
    exp_byte(0, 8'h61);
    exp_byte(1, 8'h62);
    exp_byte(2, 8'h63);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send(input logic [511:0] v, input bit stall);
    int n;
    bit pat [5];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    n = 0;
    while (!bus.block_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (!bus.block_ready) begin
      check("ready_timeout", 0, 1);
    end else begin
      bus.msg_ready = 1'b1;
      bus.message_vector = v;
      bus.block_valid = 1'b1;
      @(posedge clock); #1;
      bus.block_valid = 1'b0;
      if (stall) begin
        for (int i = 0; i < 5; i++) begin
          @(posedge clock); #1;
          bus.msg_ready = pat[i];
        end
      end
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_q.size() != 0 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (done_q.size() != 0) begin
      check("done_timeout", done_q.size(), 0);
      done_q.delete();
      byte_q.delete();
    end
  endtask

  logic [511:0] abc, v;

  initial begin
    bus.block_valid = 1'b0;
    bus.message_vector = '0;
    bus.msg_ready = 1'b1;
    abc = '0;
    abc[511:488] = 24'h616263;
    abc[487] = 1'b1;
    abc[5:0] = 6'd3;

    repeat (2) @(posedge clock);
    #1;
    check("rst_block_ready", int'(bus.block_ready), 1);
    check("rst_msg_valid", int'(bus.msg_valid), 0);
    check("rst_msg_address", int'(bus.msg_address), 0);
    check("rst_msg_data", int'(bus.msg_data), 0);
    check("rst_unpack_done", int'(bus.unpack_done), 0);
    check("rst_pad_error", int'(bus.pad_error), 0);
    check("rst_msg_length", int'(bus.msg_length), 0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // "abc" at full throughput
    exp_abc();
    exp_done(0, 3, 5);
    send(abc, 1'b0);
    check("ready_low_after_accept", int'(bus.block_ready), 0);
    wait_done();

    // "abc" with msg_ready stalls 1,0,0,1,1
    exp_abc();
    exp_done(0, 3, 7);
    send(abc, 1'b1);
    wait_done();

    // empty block
    v = '0;
    v[511] = 1'b1;
    exp_done(0, 0, 2);
    send(v, 1'b0);
    wait_done();

    // single byte boundary
    v = '0;
    v[511:504] = 8'hA5;
    v[503] = 1'b1;
    v[5:0] = 6'd1;
    exp_byte(0, 8'hA5);
    exp_done(0, 1, 3);
    send(v, 1'b0);
    wait_done();

    // length field beyond MSG_LENGTH
    v = '0;
    v[5:0] = 6'd60;
    exp_done(1, 60, 2);
    send(v, 1'b0);
    wait_done();
    check("pad_error_sticky", int'(bus.pad_error), 1);

    // missing marker bit, then a good block clears pad_error
    v = abc;
    v[487] = 1'b0;
    exp_done(1, 3, 2);
    send(v, 1'b0);
    wait_done();
    exp_abc();
    exp_done(0, 3, 5);
    send(abc, 1'b0);
    wait_done();

    // stale fill bit
    v = abc;
    v[100] = 1'b1;
`ifdef UNPACK_ZERO_CHECK_EN
    exp_done(1, 3, 2);
`else
    exp_abc();
    exp_done(0, 3, 5);
`endif
    send(v, 1'b0);
    wait_done();

    // reset during EMIT after byte 1 has handshaken
    exp_abc();
    exp_done(0, 3, 5);
    send(abc, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b0;
    bus.msg_ready = 1'b0;
    byte_q.delete();
    done_q.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    bus.msg_ready = 1'b1;
    @(negedge clock);
    check("mid_rst_msg_valid", int'(bus.msg_valid), 0);
    check("mid_rst_block_ready", int'(bus.block_ready), 1);
    check("mid_rst_pad_error", int'(bus.pad_error), 0);
    repeat (4) @(posedge clock);
    #1;
    exp_abc();
    exp_done(0, 3, 5);
    send(abc, 1'b0);
    wait_done();

    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
